// File: rtl/output_writeback_buffer_pkg.sv
// Shared types and sample conversion for the output writeback path.
// Define OUTPUT_WRITEBACK_SATURATE_EN to clamp instead of wrap when narrowing.
package output_writeback_buffer_pkg;

  localparam int IN_W         = 32;
  localparam int OUT_W        = 16;
  localparam int SHIFT_AMT    = 15;
  localparam int ADDR_W       = 8;
  localparam int SPRAM_ADDR_W = 14;
  localparam int FIFO_DEPTH   = 4;

  typedef struct packed {
    logic [OUT_W-1:0]        data;
    logic [SPRAM_ADDR_W-1:0] addr;
  } writeback_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WRITE = 2'd2
  } drain_state_t;

`ifdef OUTPUT_WRITEBACK_SATURATE_EN
  localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'(2**(OUT_W-1) - 1);
  localparam logic signed [IN_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

  // Fixed-point accumulator to sample: arithmetic shift, then narrow.
  function automatic logic [OUT_W-1:0] conv_sample(input logic [IN_W-1:0] din,
                                                   input int shift);
`ifdef OUTPUT_WRITEBACK_SATURATE_EN
    logic signed [IN_W-1:0] shifted;
    shifted = $signed(din) >>> shift;
    if (shifted > SAT_MAX) return SAT_MAX[OUT_W-1:0];
    if (shifted < SAT_MIN) return SAT_MIN[OUT_W-1:0];
    return shifted[OUT_W-1:0];
`else
    return OUT_W'($signed(din) >>> shift);
`endif
  endfunction

endpackage

// File: rtl/output_writeback_buffer_fifo.sv
// Generic synchronous FIFO with occupancy count; DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; stale contents are unreachable once the pointers and count clear.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/output_writeback_buffer.sv
// Scales core results, queues them with absolute SPRAM addresses and drains them via req/gnt.
// Define OUTPUT_WRITEBACK_SATURATE_EN to clamp narrowed samples instead of wrapping.
module output_writeback_buffer
  import output_writeback_buffer_pkg::*;
#(
  parameter int IN_BIT_WIDTH         = IN_W,
  parameter int OUT_BIT_WIDTH        = OUT_W,
  parameter int SHIFT                = SHIFT_AMT,
  parameter int ADDR_BIT_WIDTH       = ADDR_W,
  parameter int SPRAM_ADDR_BIT_WIDTH = SPRAM_ADDR_W,
  parameter int DEPTH                = FIFO_DEPTH
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [IN_BIT_WIDTH-1:0]         in_tdata,
  input  logic [ADDR_BIT_WIDTH-1:0]       in_taddress,
  input  logic                            in_twrite,
  output logic                            in_tbusy,
  input  logic [SPRAM_ADDR_BIT_WIDTH-1:0] base_address,
  output logic                            spram_req,
  input  logic                            spram_gnt,
  output logic [SPRAM_ADDR_BIT_WIDTH-1:0] spram_addr,
  output logic [OUT_BIT_WIDTH-1:0]        spram_wdata,
  output logic                            spram_we,
  output logic [$clog2(DEPTH):0]          fill_level,
  output logic                            overflow,
  input  logic                            overflow_clear
);

  writeback_entry_t push_entry, head_entry;
  logic             fifo_full, fifo_empty, push, pop;

  drain_state_t                    state_q, state_d;
  logic                            req_q, req_d;
  logic                            we_q, we_d;
  logic [SPRAM_ADDR_BIT_WIDTH-1:0] addr_q, addr_d;
  logic [OUT_BIT_WIDTH-1:0]        wdata_q, wdata_d;
  logic                            overflow_q, overflow_d;

  assign in_tbusy        = fifo_full;
  assign push            = in_twrite && !fifo_full;
  assign push_entry.data = conv_sample(in_tdata, SHIFT);
  assign push_entry.addr = base_address + SPRAM_ADDR_BIT_WIDTH'(in_taddress);

  sync_fifo #(
    .WIDTH($bits(writeback_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .resetn(resetn),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fill_level)
  );

  // The head is popped on the edge that enters WRITE, so in WRITE fill_level is the remainder.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!fifo_empty) state_d = REQ;
      REQ:     if (spram_gnt) state_d = WRITE;
      WRITE: begin
        if (fifo_empty)     state_d = IDLE;
        else if (spram_gnt) state_d = WRITE;
        else                state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    pop     = (state_d == WRITE);
    req_d   = (state_d != IDLE);
    we_d    = pop;
    addr_d  = pop ? head_entry.addr : addr_q;
    wdata_d = pop ? head_entry.data : wdata_q;

    // A new overflow outranks a simultaneous clear.
    overflow_d = overflow_q;
    if (overflow_clear)        overflow_d = 1'b0;
    if (in_twrite && fifo_full) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      overflow_q <= overflow_d;
    end
  end

  assign spram_req   = req_q;
  assign spram_we    = we_q;
  assign spram_addr  = addr_q;
  assign spram_wdata = wdata_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_output_writeback_buffer.sv
// Directed self-checking bench for output_writeback_buffer (default parameters).
module tb_output_writeback_buffer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] in_tdata = '0;
  logic [7:0]  in_taddress = '0;
  logic        in_twrite = 1'b0;
  logic        in_tbusy;
  logic [13:0] base_address = '0;
  logic        spram_req;
  logic        spram_gnt = 1'b0;
  logic [13:0] spram_addr;
  logic [15:0] spram_wdata;
  logic        spram_we;
  logic [2:0]  fill_level;
  logic        overflow;
  logic        overflow_clear = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [29:0] seen[$];
  logic [29:0] expq[$];
  logic [2:0]  max_fill;
  logic        busy_seen;

  output_writeback_buffer dut (
    .clk           (clk),
    .resetn        (resetn),
    .in_tdata      (in_tdata),
    .in_taddress   (in_taddress),
    .in_twrite     (in_twrite),
    .in_tbusy      (in_tbusy),
    .base_address  (base_address),
    .spram_req     (spram_req),
    .spram_gnt     (spram_gnt),
    .spram_addr    (spram_addr),
    .spram_wdata   (spram_wdata),
    .spram_we      (spram_we),
    .fill_level    (fill_level),
    .overflow      (overflow),
    .overflow_clear(overflow_clear)
  );

  always #5 clk = ~clk;

  // Record every completed SPRAM write as {addr, data}.
  always @(negedge clk) begin
    if (resetn && spram_we) seen.push_back({spram_addr, spram_wdata});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (fill_level > max_fill) max_fill = fill_level;
    if (in_tbusy) busy_seen = 1'b1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [31:0] d);
    in_twrite   = 1'b1;
    in_taddress = a;
    in_tdata    = d;
    tick();
  endtask

  task automatic wait_drain(input string tag);
    int n;
    for (int i = 0; i < 60 && seen.size() < expq.size(); i++) tick();
    for (int i = 0; i < 3; i++) tick();
    check({tag, "_count"}, seen.size(), expq.size());
    n = (seen.size() < expq.size()) ? seen.size() : expq.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_w%0d", tag, i), seen[i], expq[i]);
    seen.delete();
    expq.delete();
  endtask

  initial begin
    int wecnt;
    logic [15:0] exp_pos, exp_neg_big, exp_max;

    // Reset state
    max_fill = '0;
    busy_seen = 1'b0;
    tick();
    tick();
    check("rst_req", spram_req, 0);
    check("rst_we", spram_we, 0);
    check("rst_fill", fill_level, 0);
    check("rst_busy", in_tbusy, 0);
    check("rst_ovf", overflow, 0);
    check("rst_addr", spram_addr, 0);
    check("rst_wdata", spram_wdata, 0);
    resetn = 1'b1;
    tick();

    // Single write and its latency
    spram_gnt    = 1'b1;
    base_address = 14'h0100;
    drive(8'h05, 32'h0000_8000);
    in_twrite = 1'b0;
    check("single_fill", fill_level, 1);
    check("single_n1_req", spram_req, 0);
    tick();
    check("single_n2_req", spram_req, 1);
    check("single_n2_we", spram_we, 0);
    tick();
    check("single_n3_we", spram_we, 1);
    check("single_addr", spram_addr, 14'h0105);
    check("single_wdata", spram_wdata, 16'h0001);
    tick();
    check("single_n4_we", spram_we, 0);
    check("single_n4_req", spram_req, 0);
    check("single_hold_addr", spram_addr, 14'h0105);
    check("single_hold_wdata", spram_wdata, 16'h0001);
    expq.push_back({14'h0105, 16'h0001});
    wait_drain("single");

    // Burst with grant held
    base_address = 14'h0000;
    max_fill = '0;
    busy_seen = 1'b0;
    drive(8'h00, 32'h0000_8000);
    drive(8'h01, 32'h0001_0000);
    drive(8'h02, 32'h0001_8000);
    drive(8'h03, 32'h0002_0000);
    in_twrite = 1'b0;
    expq.push_back({14'h0000, 16'h0001});
    expq.push_back({14'h0001, 16'h0002});
    expq.push_back({14'h0002, 16'h0003});
    expq.push_back({14'h0003, 16'h0004});
    wait_drain("burst");
    check("burst_peak_le3", (max_fill <= 3'd3), 1);
    check("burst_no_busy", busy_seen, 0);

    // Backpressure: 5 attempts with no grant
    spram_gnt    = 1'b0;
    base_address = 14'h0200;
    drive(8'h10, 32'h0005_0000);
    drive(8'h11, 32'h0005_8000);
    drive(8'h12, 32'h0006_0000);
    drive(8'h13, 32'h0006_8000);
    drive(8'h14, 32'h0007_0000);
    in_twrite = 1'b0;
    check("bp_busy", in_tbusy, 1);
    check("bp_fill", fill_level, 4);
    check("bp_ovf", overflow, 1);
    check("bp_req", spram_req, 1);
    check("bp_no_we", spram_we, 0);
    in_twrite      = 1'b1;
    overflow_clear = 1'b1;
    tick();
    in_twrite      = 1'b0;
    overflow_clear = 1'b0;
    check("bp_set_wins", overflow, 1);
    check("bp_fill_kept", fill_level, 4);
    expq.push_back({14'h0210, 16'h000A});
    expq.push_back({14'h0211, 16'h000B});
    expq.push_back({14'h0212, 16'h000C});
    expq.push_back({14'h0213, 16'h000D});
    spram_gnt = 1'b1;
    wait_drain("bp");
    check("bp_ovf_sticky", overflow, 1);
    overflow_clear = 1'b1;
    tick();
    overflow_clear = 1'b0;
    check("bp_ovf_clear", overflow, 0);

    // Grant loss after the second write
    spram_gnt    = 1'b0;
    base_address = 14'h0300;
    drive(8'h20, 32'hFFFF_8000);
    drive(8'h21, 32'h3FFF_8000);
    drive(8'h22, 32'h0000_7FFF);
    drive(8'h23, 32'hFFFF_0000);
    in_twrite = 1'b0;
    tick();
    check("gl_req_wait", spram_req, 1);
    spram_gnt = 1'b1;
    wecnt = 0;
    for (int i = 0; i < 10 && wecnt < 2; i++) begin
      tick();
      if (spram_we) wecnt++;
    end
    check("gl_two_writes", wecnt, 2);
    spram_gnt = 1'b0;
    tick();
    check("gl_back_req", spram_req, 1);
    check("gl_back_we", spram_we, 0);
    wecnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (spram_we) wecnt++;
    end
    check("gl_stalled_we", wecnt, 0);
    check("gl_stalled_fill", fill_level, 2);
    expq.push_back({14'h0320, 16'hFFFF});
    expq.push_back({14'h0321, 16'h7FFF});
    expq.push_back({14'h0322, 16'h0000});
    expq.push_back({14'h0323, 16'hFFFE});
    spram_gnt = 1'b1;
    wait_drain("gl");

    // Conversion boundaries and address wrap
`ifdef OUTPUT_WRITEBACK_SATURATE_EN
    exp_pos     = 16'h7FFF;
    exp_neg_big = 16'h8000;
    exp_max     = 16'h7FFF;
`else
    exp_pos     = 16'h8000;
    exp_neg_big = 16'h0000;
    exp_max     = 16'hFFFF;
`endif
    base_address = 14'h3FFF;
    drive(8'h02, 32'h4000_0000);
    drive(8'h03, 32'hC000_0000);
    drive(8'h00, 32'h8000_0000);
    drive(8'hFF, 32'h7FFF_FFFF);
    in_twrite = 1'b0;
    expq.push_back({14'h0001, exp_pos});
    expq.push_back({14'h0002, 16'h8000});
    expq.push_back({14'h3FFF, exp_neg_big});
    expq.push_back({14'h00FE, exp_max});
    wait_drain("conv");

    // Reset in the middle of a drain
    spram_gnt    = 1'b0;
    base_address = 14'h0000;
    drive(8'h30, 32'h0000_8000);
    drive(8'h31, 32'h0001_0000);
    drive(8'h32, 32'h0001_8000);
    in_twrite = 1'b0;
    spram_gnt = 1'b1;
    wecnt = 0;
    for (int i = 0; i < 10 && wecnt == 0; i++) begin
      tick();
      if (spram_we) wecnt++;
    end
    check("mr_first_we", wecnt, 1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("mr_we", spram_we, 0);
    check("mr_req", spram_req, 0);
    check("mr_fill", fill_level, 0);
    wecnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (spram_we || spram_req) wecnt++;
    end
    check("mr_no_more", wecnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/output_writeback_buffer.md
Name: output_writeback_buffer

Overview:
- Sits directly downstream of each DSP processor core's output write port; accepts one accumulator result per write pulse.
- Scales each result to sample width and queues it with its block address in a small FIFO.
- Drains the FIFO to the shared output SPRAM write port through a request/grant handshake.
- Drives the core's output busy signal so the core stalls instead of losing writes.

Parameters:
- IN_BIT_WIDTH, 32, width of the incoming accumulator result (signed, two's complement)
- OUT_BIT_WIDTH, 16, width of the word written to SPRAM
- SHIFT, 15, arithmetic right shift applied before narrowing (fixed-point fraction bits)
- ADDR_BIT_WIDTH, 8, core-relative output block address width
- SPRAM_ADDR_BIT_WIDTH, 14, absolute SPRAM address width
- DEPTH, 4, FIFO entries; power of two, minimum 2

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- in_tdata  in  IN_BIT_WIDTH  result from core
- in_taddress  in  ADDR_BIT_WIDTH  core-relative output address
- in_twrite  in  1  write strobe, one word per cycle high
- in_tbusy  out  1  high when FIFO full; core must hold
- base_address  in  SPRAM_ADDR_BIT_WIDTH  region base added to in_taddress; quasi-static
- spram_req  out  1  request shared write port
- spram_gnt  in  1  arbiter grant, same-cycle response to req allowed
- spram_addr  out  SPRAM_ADDR_BIT_WIDTH  write address
- spram_wdata  out  OUT_BIT_WIDTH  write data
- spram_we  out  1  write enable, one word per cycle high
- fill_level  out  clog2(DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky: write attempted while full
- overflow_clear  in  1  clears overflow

Behaviour:
- Reset: all outputs 0; FIFO empty; state IDLE; overflow 0. Reset mid-drain discards queued entries. No partial write: we is registered and drops with reset.
- in_tbusy = (fill_level == DEPTH), combinational from registered count.
- Push: in_twrite && !in_tbusy.
  - Stores conv(in_tdata) and (base_address + zero-extended in_taddress), truncated to SPRAM_ADDR_BIT_WIDTH (wrap).
  - base_address is sampled at push.
- Write while full: dropped, overflow <= 1. A pop in the same cycle does not make room (busy is decided from pre-cycle count).
- overflow_clear and a new overflow in the same cycle: overflow ends up 1 (set wins).
- conv: arithmetic shift right by SHIFT, then take the low OUT_BIT_WIDTH bits (truncation, wraps on overflow).
- Drain FSM, registered outputs:
  - IDLE: req=0, we=0. If fill_level>0, go to REQ.
  - REQ: req=1. If spram_gnt, go to WRITE.
  - WRITE: req=1, we=1; addr/wdata = head entry; pop at end of cycle.
    - Remaining>0 and gnt: stay in WRITE (burst, one word per cycle).
    - Remaining>0 and !gnt: go to REQ.
    - Remaining==0: go to IDLE.
  - Grant is checked in WRITE for continuation only. The current write always completes, because grant was held when the state was entered.
- Latency: push at cycle N gives we at N+3 minimum (IDLE sees data at N+1, req at N+2, we at N+3 with gnt).
- Simultaneous push and pop: both occur; count unchanged. Push into an empty FIFO while popping is not possible (pop requires an entry).
- Pointers wrap modulo DEPTH. Order is strictly FIFO.
- spram_addr/spram_wdata hold the last value when we=0.

Optional Feature:
- OUTPUT_WRITEBACK_SATURATE_EN defined: after the shift, values above 2^(OUT_BIT_WIDTH-1)-1 clamp to 0x7FFF and values below -2^(OUT_BIT_WIDTH-1) clamp to 0x8000 (defaults shown).
- Undefined: plain truncation as above.

Decomposition:
- Shared package: writeback_entry_t struct {data, addr}, the drain state enum (IDLE/REQ/WRITE), and the saturate/truncate conversion function.
- One natural sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty/count), reusable for a sample prefetch buffer.

Test Plan:
- Single write: in_tdata=0x0000_8000, in_taddress=0x05, base=0x0100, gnt tied 1 -> one we pulse 3 cycles later, addr 0x0105, wdata 0x0001.
- Burst with gnt held 1: 4 back-to-back writes, addresses 0..3 -> 4 consecutive we cycles in order. in_tbusy never high if draining keeps pace; fill_level peaks at 3 or less.
- Backpressure: gnt=0, 5 writes attempted -> first 4 accepted, in_tbusy=1, 5th dropped, overflow=1. Release gnt -> 4 writes in order, then overflow_clear -> overflow=0.
- Grant loss mid-burst: gnt drops after the 2nd we -> FSM returns to REQ, req stays 1, remaining entries written after gnt returns, none duplicated or skipped.
- Conversion: in_tdata=0x4000_0000 -> 0x8000 truncated (macro off), 0x7FFF (macro on). in_tdata=0xC000_0000 -> 0x8000 both.
- Reset mid-drain with 3 queued: assert resetn=0 one cycle -> we/req 0 next edge, fill_level 0, no further writes.
